// File: rtl/out_port_seg_driver.sv
// -----------------------------------------------------------------------------
// out_port_seg_driver
//
// Purpose: takes a 32-bit unsigned value written to an output port, converts
// it to ten BCD digits with a sequential double-dabble (one bit per clock),
// and drives six active-low seven-segment displays. Values above 999999 are
// flagged with overflow and shown as dashes on every display. A write that
// arrives during a conversion is held in a one-entry pending buffer (last
// write wins) and converted immediately after the current one finishes.
//
// Parameters:
//   BLANK_ZEROS  1: blank leading-zero digits (HEX0 always shown)
//                0: show all six digits
//
// Ports:
//   clock     in   1   sole clock, rising edge
//   resetn    in   1   synchronous active-low reset
//   wr_en     in   1   write strobe for a new value
//   wr_data   in  32   unsigned binary value to display
//   busy      out  1   conversion in progress
//   done      out  1   one-cycle pulse when the displays update
//   overflow  out  1   last displayed value exceeded 999999
//   HEX0..5   out  7   active-low segments {g,f,e,d,c,b,a}, HEX0 = units
// -----------------------------------------------------------------------------
module out_port_seg_driver #(
  parameter int BLANK_ZEROS = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  // Upper digits after reset mirror what a displayed zero looks like
  localparam logic [6:0] RST_UPPER = (BLANK_ZEROS != 0) ? SEG_BLANK : SEG_ZERO;

  state_t            r_state;
  logic [31:0]       r_bin;
  logic [39:0]       r_bcd;
  logic [4:0]        r_iter;
  logic              r_pend_valid;
  logic [31:0]       r_pend_data;
  logic              r_busy;
  logic              r_done;
  logic              r_overflow;
  logic [5:0][6:0]   r_hex;

  logic [39:0]       w_bcd_adj;
  logic [5:0][6:0]   w_hex;
  logic              w_overflow;
  logic              w_seen;

  // Active-low seven-segment pattern for one BCD digit
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < 10; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) begin
        w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
      end else begin
        w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4];
      end
    end
  end

  // Segment patterns for the finished conversion: dashes on overflow,
  // otherwise blank every digit above the most significant nonzero one
  always_comb begin
    w_overflow = (r_bcd[39:24] != 16'd0);
    w_seen     = 1'b0;
    w_hex      = '0;
    for (int d = 5; d >= 0; d--) begin
      if ((r_bcd[d*4 +: 4] != 4'd0) || (d == 0)) begin
        w_seen = 1'b1;
      end else begin
        w_seen = w_seen;
      end
      if (w_overflow) begin
        w_hex[d] = SEG_DASH;
      end else if ((BLANK_ZEROS != 0) && !w_seen) begin
        w_hex[d] = SEG_BLANK;
      end else begin
        w_hex[d] = seg_encode(r_bcd[d*4 +: 4]);
      end
    end
  end

  // Conversion FSM, pending-write buffer and registered display outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_bin        <= 32'd0;
      r_bcd        <= 40'd0;
      r_iter       <= 5'd0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_hex[0]     <= SEG_ZERO;
      r_hex[1]     <= RST_UPPER;
      r_hex[2]     <= RST_UPPER;
      r_hex[3]     <= RST_UPPER;
      r_hex[4]     <= RST_UPPER;
      r_hex[5]     <= RST_UPPER;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wr_en) begin
            r_bin   <= wr_data;
            r_bcd   <= 40'd0;
            r_iter  <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (wr_en) begin
            r_pend_valid <= 1'b1;
            r_pend_data  <= wr_data;
          end else begin
            r_pend_valid <= r_pend_valid;
          end
          r_bcd  <= {w_bcd_adj[38:0], r_bin[31]};
          r_bin  <= {r_bin[30:0], 1'b0};
          r_iter <= r_iter + 5'd1;
          if (r_iter == 5'd31) begin
            r_state <= UPDATE;
          end else begin
            r_state <= SHIFT;
          end
        end
        UPDATE: begin
          r_hex      <= w_hex;
          r_overflow <= w_overflow;
          r_done     <= 1'b1;
          r_bcd      <= 40'd0;
          r_iter     <= 5'd0;
          // A write on this very edge is newer than anything pending
          if (wr_en) begin
            r_bin        <= wr_data;
            r_pend_valid <= 1'b0;
            r_state      <= SHIFT;
          end else if (r_pend_valid) begin
            r_bin        <= r_pend_data;
            r_pend_valid <= 1'b0;
            r_state      <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_pend_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign HEX0     = r_hex[0];
  assign HEX1     = r_hex[1];
  assign HEX2     = r_hex[2];
  assign HEX3     = r_hex[3];
  assign HEX4     = r_hex[4];
  assign HEX5     = r_hex[5];

endmodule

// File: doc/out_port_seg_driver.md
OUT_PORT_SEG_DRIVER -- requirements
Module: out_port_seg_driver

Interface
REQ-001 SHALL have parameter BLANK_ZEROS, default 1, meaning leading-zero digits are blanked (0 = all six digits shown).
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port wr_en  input  1  write strobe for a new output-port value.
REQ-005 SHALL have port wr_data  input  32  unsigned binary value to display.
REQ-006 SHALL have port busy  output  1  conversion in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when displays update.
REQ-008 SHALL have port overflow  output  1  last displayed value exceeded 999999.
REQ-009 SHALL have ports HEX0..HEX5  output  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 is the units digit.

Function
REQ-010 SHALL convert wr_data to 10 BCD digits by sequential shift-add-3 (double dabble): one bit per clock, 32 iteration cycles.
REQ-011 SHALL use FSM states IDLE, SHIFT, UPDATE: IDLE->SHIFT on accepted write; SHIFT->UPDATE after iteration 31; UPDATE->SHIFT if a write is queued, else UPDATE->IDLE.
REQ-012 SHALL accept wr_en in IDLE at edge E0, raise busy after E0, shift at E1..E32, and register HEX/overflow with done=1 after E33 (latency 33 clocks, write to display).
REQ-013 SHALL keep busy=1 continuously across back-to-back conversions, with no IDLE cycle in between.
REQ-014 SHALL store any wr_en while busy=1 in a one-entry pending buffer; a newer write overwrites an older pending value (last write wins).
REQ-015 SHALL start the pending value at the UPDATE edge, clearing pending; wr_en at the UPDATE edge itself takes precedence and discards the older pending value.
REQ-016 SHALL leave HEX outputs unchanged during conversion; HEX changes only at the UPDATE edge.
REQ-017 SHALL encode digits 0-9 as 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000.
REQ-018 SHALL, with BLANK_ZEROS=1, drive 1111111 on every digit above the most significant nonzero digit; HEX0 is never blanked.
REQ-019 SHALL, when any of BCD digits 6-9 is nonzero, set overflow=1 and drive 0111111 (dash) on all six HEX outputs.
REQ-020 SHALL clear overflow at the next UPDATE whose value is <= 999999.
REQ-021 SHALL drive done=1 for exactly one cycle per completed conversion, including back-to-back conversions.

Reset
REQ-022 SHALL, on any edge with resetn=0, force state IDLE, busy=0, done=0, overflow=0, pending cleared, shift register and iteration counter zeroed.
REQ-023 SHALL, on reset, drive HEX0=1000000 and HEX1..HEX5=1111111 (BLANK_ZEROS=1) or 1000000 (BLANK_ZEROS=0).
REQ-024 SHALL abort a conversion on reset mid-SHIFT; the aborted value never reaches HEX, and done is not pulsed.
REQ-025 SHALL ignore wr_en on any edge where resetn=0.

Verification
REQ-026 SHALL cover: write 123456 from IDLE -> busy 33 cycles; done pulse; HEX5..HEX0 = 1111001,0100100,0110000,0011001,0010010,0000010; overflow=0.
REQ-027 SHALL cover: write 7 with BLANK_ZEROS=1 -> HEX0=1111000, HEX1..HEX5=1111111; with BLANK_ZEROS=0 -> HEX1..HEX5=1000000.
REQ-028 SHALL cover: write 1000000, then 0xFFFFFFFF -> all HEX=0111111, overflow=1; then write 999999 -> all HEX=0010000, overflow=0.
REQ-029 SHALL cover: write 11, then writes 22 and 33 during busy -> exactly two done pulses, first showing 11 and second showing 33; busy high for 66 consecutive cycles; 22 never displayed.
REQ-030 SHALL cover: write 555, then resetn=0 at iteration 10 -> next edge busy=0 and HEX shows reset pattern; no done pulse; following write 9 -> HEX0=0010000 after 33 cycles.
REQ-031 SHALL cover: wr_en with 42 on the UPDATE edge while 5 is pending -> 42 is converted next and 5 is discarded.
